uart_tx_framer: RTL

Parametrised UART transmit framer. It accepts one parallel word per handshake and serialises it onto a registered line output: start bit, `DATA_WIDTH` data bits LSB-first, an optional even/odd parity bit, then one or two stop bits. The parity mode and stop count are selected per frame. It generalises the fixed 4-way TX output-select stage into a self-sequencing frame engine with gapless back-to-back frames. It sits between the TX data source (FIFO/ALU result path) and the `tx_out` pin, clocked at one bit per `clk`.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_framer_if.sv | 23 ++
 rtl/uart_parity_calc.sv | 14 +
 rtl/uart_tx_framer.sv | 108 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-engine states, parity selectors and line levels.
// Used by the TX framer and the RX checker.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Frame length in bit times for a given data width and per-frame options.
    function automatic int frame_len(input int data_width, input logic par_en, input logic stop2);
        return 1 + data_width + int'(par_en) + 1 + int'(stop2);
    endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Word-source side of the UART TX framer: handshake, per-frame options and the serial line.
interface uart_tx_framer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  par_en;
    logic                  par_type;
    logic                  stop2;
    logic                  ready;
    logic                  busy;
    logic                  tx_out;

    modport master (
        output data_valid, p_data, par_en, par_type, stop2,
        input  ready, busy, tx_out
    );

    modport slave (
        input  data_valid, p_data, par_en, par_type, stop2,
        output ready, busy, tx_out
    );
endinterface

// File: rtl/uart_parity_calc.sv
// Combinational parity generator; even returns the XOR of the data bits, odd its inverse.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_type,
    output logic                  parity
);

    assign parity = (^data) ^ (par_type == PAR_ODD);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, DATA_WIDTH data bits LSB-first, optional parity, 1 or 2 stops,
// one bit per clk, with gapless back-to-back frames when a word is accepted in the final stop bit.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_framer_if.slave  tx
);

    localparam int            CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    state_t                state_q, state_n;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_n;
    logic                  stop_cnt_q, stop_cnt_n;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q, par_type_q, stop2_q;
    logic                  tx_q;
    logic                  line_n;
    logic                  par_bit;
    logic                  last_stop;
    logic                  accept;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data     (data_q),
        .par_type (par_type_q),
        .parity   (par_bit)
    );

    // The final stop bit is the only STOP cycle that can hand over to a new frame.
    assign last_stop  = (state_q == STOP) && (stop_cnt_q == stop2_q);
    assign tx.ready   = (state_q == IDLE) || last_stop;
    assign tx.busy    = (state_q != IDLE);
    assign accept     = tx.data_valid && tx.ready;
    assign tx.tx_out  = tx_q;

    always_comb begin
        state_n    = state_q;
        bit_cnt_n  = bit_cnt_q;
        stop_cnt_n = stop_cnt_q;
        line_n     = LINE_IDLE;

        case (state_q)
            IDLE: begin
                if (accept) state_n = START;
            end
            START: begin
                state_n   = DATA;
                bit_cnt_n = '0;
            end
            DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
                    state_n    = par_en_q ? PARITY : STOP;
                    stop_cnt_n = 1'b0;
                end else begin
                    bit_cnt_n = bit_cnt_q + CW'(1);
                end
            end
            PARITY: begin
                state_n    = STOP;
                stop_cnt_n = 1'b0;
            end
            STOP: begin
                if (last_stop) state_n = accept ? START : IDLE;
                else           stop_cnt_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        // The pin flop loads the level of the state being entered, so it lines up with that state.
        case (state_n)
            START:   line_n = LINE_START;
            DATA:    line_n = data_q[bit_cnt_n];
            PARITY:  line_n = par_bit;
            default: line_n = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= PAR_EVEN;
            stop2_q    <= 1'b0;
            tx_q       <= LINE_IDLE;
        end else begin
            state_q    <= state_n;
            bit_cnt_q  <= bit_cnt_n;
            stop_cnt_q <= stop_cnt_n;
            tx_q       <= line_n;
            if (accept) begin
                data_q     <= tx.p_data;
                par_en_q   <= tx.par_en;
                par_type_q <= tx.par_type;
                stop2_q    <= tx.stop2;
            end
        end
    end

endmodule
